router_op_lut_cntr_sched: RTL

- Scheduler between the output-port lookup event sources and the generic counter-register block.
- Accepts raw single-cycle event pulses on up to NUM_EVENTS lines; pulses may be simultaneous or back-to-back.
- Buffers each event in a per-line pending count and replays the events as one-hot update pulses.
- Output pulses respect the counter block's minimum update interval per line; at most one update is issued per cycle, with round-robin arbitration.

---
 rtl/router_op_lut_cntr_sched.sv | 119 +++++++++++
 1 files changed

// File: rtl/router_op_lut_cntr_sched.sv
// rtl/router_op_lut_cntr_sched.sv - buffers output-port lookup events and replays them as rate-limited round-robin counter updates
module router_op_lut_cntr_sched #(
    parameter int NUM_EVENTS          = 10,
    parameter int PEND_WIDTH          = 4,
    parameter int MIN_UPDATE_INTERVAL = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NUM_EVENTS-1:0] event_in,
    input  logic                  sched_en,
    output logic [NUM_EVENTS-1:0] updates,
    output logic                  pending_any,
    output logic [NUM_EVENTS-1:0] sat_err
);

    localparam int PTR_W  = (NUM_EVENTS > 1) ? $clog2(NUM_EVENTS) : 1;
    localparam int HOLD_W = (MIN_UPDATE_INTERVAL > 1) ? $clog2(MIN_UPDATE_INTERVAL) : 1;
    localparam logic [HOLD_W-1:0]     HOLD_RELOAD = HOLD_W'(MIN_UPDATE_INTERVAL - 1);
    localparam logic [PEND_WIDTH-1:0] PEND_MAX    = '1;
    localparam logic [PTR_W-1:0]      PTR_LAST    = PTR_W'(NUM_EVENTS - 1);

    logic [PEND_WIDTH-1:0] pend     [NUM_EVENTS];
    logic [PEND_WIDTH-1:0] pend_nxt [NUM_EVENTS];
    logic [HOLD_W-1:0]     hold     [NUM_EVENTS];
    logic [HOLD_W-1:0]     hold_nxt [NUM_EVENTS];
    logic [PTR_W-1:0]      rr_ptr;
    logic [PTR_W-1:0]      rr_nxt;

    logic [NUM_EVENTS-1:0] elig;
    logic [NUM_EVENTS-1:0] grant;
    logic                  grant_vld;
    logic [PTR_W-1:0]      grant_idx;
    logic [NUM_EVENTS-1:0] sat_nxt;
    logic                  pend_any_nxt;

    always_comb begin
        for (int i = 0; i < NUM_EVENTS; i++) begin
            elig[i] = sched_en && (pend[i] != '0) && (hold[i] == '0);
        end
    end

    // Rotating priority scan starting at rr_ptr; first eligible line wins.
    always_comb begin
        logic [PTR_W:0]   sum;
        logic [PTR_W-1:0] idx;
        grant     = '0;
        grant_vld = 1'b0;
        grant_idx = '0;
        sum       = '0;
        idx       = '0;
        for (int k = 0; k < NUM_EVENTS; k++) begin
            sum = {1'b0, rr_ptr} + (PTR_W+1)'(k);
            if (sum >= (PTR_W+1)'(NUM_EVENTS)) begin
                sum = sum - (PTR_W+1)'(NUM_EVENTS);
            end
            idx = sum[PTR_W-1:0];
            if (!grant_vld && elig[idx]) begin
                grant_vld  = 1'b1;
                grant_idx  = idx;
                grant[idx] = 1'b1;
            end
        end
    end

    always_comb begin
        rr_nxt       = rr_ptr;
        sat_nxt      = '0;
        pend_any_nxt = 1'b0;
        if (grant_vld) begin
            rr_nxt = (grant_idx == PTR_LAST) ? '0 : grant_idx + PTR_W'(1);
        end
        for (int i = 0; i < NUM_EVENTS; i++) begin
            if (grant[i]) begin
                hold_nxt[i] = HOLD_RELOAD;
            end else if (hold[i] != '0) begin
                hold_nxt[i] = hold[i] - HOLD_W'(1);
            end else begin
                hold_nxt[i] = '0;
            end
            pend_nxt[i] = pend[i];
            // An event arriving on the grant edge cancels the drain, so it can never saturate.
            case ({event_in[i], grant[i]})
                2'b10: begin
                    if (pend[i] == PEND_MAX) begin
                        sat_nxt[i] = 1'b1;
                    end else begin
                        pend_nxt[i] = pend[i] + PEND_WIDTH'(1);
                    end
                end
                2'b01:   pend_nxt[i] = pend[i] - PEND_WIDTH'(1);
                default: pend_nxt[i] = pend[i];
            endcase
            pend_any_nxt = pend_any_nxt | (pend_nxt[i] != '0);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_EVENTS; i++) begin
                pend[i] <= '0;
                hold[i] <= '0;
            end
            rr_ptr      <= '0;
            updates     <= '0;
            pending_any <= 1'b0;
            sat_err     <= '0;
        end else begin
            for (int i = 0; i < NUM_EVENTS; i++) begin
                pend[i] <= pend_nxt[i];
                hold[i] <= hold_nxt[i];
            end
            rr_ptr      <= rr_nxt;
            updates     <= grant;
            pending_any <= pend_any_nxt;
            sat_err     <= sat_nxt;
        end
    end

endmodule
